// File: rtl/skolem_urem_uge_witness_checker_pkg.sv
// Shared types and the invertibility-condition helper for the urem/uge witness checker.
// The bench reuses the same helper as its reference for IC.
package skolem_urem_uge_witness_checker_pkg;

    localparam int W_DEF     = 4;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_e;

    // A solution x with (x urem s) >=u t exists iff t <=u ~(-s).
    function automatic logic ic_urem_uge(input logic [W_DEF-1:0] s, input logic [W_DEF-1:0] t);
        logic [W_DEF-1:0] neg_s;
        logic [W_DEF-1:0] inv_neg_s;
        neg_s     = ~s + W_DEF'(1);
        inv_neg_s = ~neg_s;
        return (t <= inv_neg_s);
    endfunction

endpackage

// File: rtl/skolem_urem_uge_witness_checker_div.sv
// Bit-serial restoring divider: loads on start, then W MSB-first steps yield x urem s.
// done marks the cycle whose closing edge performs the final step.
module urem_serial_div
    import skolem_urem_uge_witness_checker_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] s,
    input  logic [W-1:0] x,
    output logic         done,
    output logic [W-1:0] rem
);

    localparam int CNT_BITS = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_BITS-1:0] LAST_STEP = CNT_BITS'(W - 1);

    logic [W:0]          r_q, r_d;
    logic [W-1:0]        xs_q, xs_d;
    logic [W-1:0]        x_q, x_d;
    logic [W-1:0]        s_q, s_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [W:0]          r_shift_s;
    logic [W:0]          r_sub_s;
    logic                done_s;

    // One restoring step per busy cycle; start reloads all state.
    always_comb begin
        r_d       = r_q;
        xs_d      = xs_q;
        x_d       = x_q;
        s_d       = s_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_s    = 1'b0;
        r_shift_s = {r_q[W-1:0], xs_q[W-1]};
        r_sub_s   = r_shift_s - {1'b0, s_q};
        if (start) begin
            r_d    = '0;
            xs_d   = x;
            x_d    = x;
            s_d    = s;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            r_d   = (r_shift_s >= {1'b0, s_q}) ? r_sub_s : r_shift_s;
            xs_d  = {xs_q[W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_BITS'(1);
            if (cnt_q == LAST_STEP) begin
                busy_d = 1'b0;
                done_s = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            xs_q   <= '0;
            x_q    <= '0;
            s_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            xs_q   <= xs_d;
            x_q    <= x_d;
            s_q    <= s_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign done = done_s;
    // x urem 0 is x; the iteration would also produce it, but the override makes it explicit.
    assign rem  = (s_q == '0) ? x_q : r_q[W-1:0];

endmodule

// File: rtl/skolem_urem_uge_witness_checker.sv
// Checks a Skolem witness x for (x urem s) >=u t: serial urem, IC/goal compare,
// valid/ready handshakes and saturating check/failure counters.
module skolem_urem_uge_witness_checker
    import skolem_urem_uge_witness_checker_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     s,
    input  logic [W-1:0]     t,
    input  logic [W-1:0]     x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_rem,
    output logic             out_ic,
    output logic             out_sat,
    output logic             out_ok,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    state_e           state_q, state_d;
    logic [W-1:0]     s_q, s_d;
    logic [W-1:0]     t_q, t_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_rem_q, out_rem_d;
    logic             out_ic_q, out_ic_d;
    logic             out_sat_q, out_sat_d;
    logic             out_ok_q, out_ok_d;
    logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             div_start_s;
    logic             div_done_s;
    logic [W-1:0]     div_rem_s;
    logic             ic_s;
    logic             sat_s;

    urem_serial_div #(.W(W)) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start_s),
        .s     (s),
        .x     (x),
        .done  (div_done_s),
        .rem   (div_rem_s)
    );

    // Next-state, result capture and counter update.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        t_d         = t_q;
        out_valid_d = out_valid_q;
        out_rem_d   = out_rem_q;
        out_ic_d    = out_ic_q;
        out_sat_d   = out_sat_q;
        out_ok_d    = out_ok_q;
        chk_cnt_d   = chk_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        div_start_s = 1'b0;
        ic_s        = ic_urem_uge(s_q, t_q);
        sat_s       = (div_rem_s >= t_q);
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    s_d         = s;
                    t_d         = t;
                    div_start_s = 1'b1;
                    state_d     = DIV;
                end else begin
                    state_d = IDLE;
                end
            end
            DIV: begin
                if (div_done_s) begin
                    state_d = CMP;
                end else begin
                    state_d = DIV;
                end
            end
            CMP: begin
                out_rem_d   = div_rem_s;
                out_ic_d    = ic_s;
                out_sat_d   = sat_s;
                out_ok_d    = ~ic_s | sat_s;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    chk_cnt_d   = sat_inc(chk_cnt_q);
                    if (!out_ok_q) begin
                        fail_cnt_d = sat_inc(fail_cnt_q);
                    end else begin
                        fail_cnt_d = fail_cnt_q;
                    end
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
        in_ready_d = (state_d == IDLE);
    end

    // Control, operand and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            t_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_rem_q   <= '0;
            out_ic_q    <= 1'b0;
            out_sat_q   <= 1'b0;
            out_ok_q    <= 1'b0;
            chk_cnt_q   <= '0;
            fail_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            t_q         <= t_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_rem_q   <= out_rem_d;
            out_ic_q    <= out_ic_d;
            out_sat_q   <= out_sat_d;
            out_ok_q    <= out_ok_d;
            chk_cnt_q   <= chk_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_rem   = out_rem_q;
    assign out_ic    = out_ic_q;
    assign out_sat   = out_sat_q;
    assign out_ok    = out_ok_q;
    assign chk_cnt   = chk_cnt_q;
    assign fail_cnt  = fail_cnt_q;

endmodule
